mem_stage_ls: RTL and testbench

//  MEM pipeline stage with load/store support. Sits between EX and WB.
//  - Registers the EX result toward WB.
//  - Runs data-memory accesses over a req/ack bus with a wait-state and timeout FSM.
//  - Stalls upstream until each access completes.
//  - Formats loads (sign/zero extend) and stores (lane steering, byte enables).

---
 rtl/mem_stage_ls.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mem_stage_ls.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ls.sv
// mem_stage_ls: MEM pipeline stage between EX and WB.
// Forwards ALU results to WB. Runs load/store accesses on a req/ack data bus
// with a wait-state counter and optional timeout. Holds EX stalled while an
// access is outstanding. Formats load data and steers store data into lanes.
module mem_stage_ls #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_WAIT   = 16,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_sdata_i,
  output logic              stall_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              exc_align_o,
  output logic              exc_bus_o
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_e;

  // Counter only needs to reach MAX_WAIT-1; with MAX_WAIT=0 it simply wraps.
  localparam int unsigned   CW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [REG_AW-1:0]   wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         mwdata_q, mwdata_d;
  logic [3:0]          op_q, op_d;
  logic [1:0]          lo_q, lo_d;
  logic [REG_AW-1:0]   lwd_q, lwd_d;
  logic                lwreg_q, lwreg_d;
  logic                exc_align_q, exc_align_d;
  logic                exc_bus_q, exc_bus_d;

  logic                dec_mem;
  logic                dec_store;
  size_e               dec_size;
  logic                dec_misalign;
  logic [1:0]          st_lane;
  logic                st_hsel;
  logic [3:0]          st_be;
  logic [31:0]         st_wdata;
  logic [1:0]          ld_lane;
  logic                ld_hsel;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_data;
  logic                timeout;

  // Classify the incoming opcode: memory or not, direction, size, alignment.
  always_comb begin
    dec_mem      = 1'b0;
    dec_store    = 1'b0;
    dec_size     = SZ_B;
    dec_misalign = 1'b0;
    case (mem_op_i)
      OP_LB, OP_LBU: begin dec_mem = 1'b1; dec_size = SZ_B; end
      OP_LH, OP_LHU: begin dec_mem = 1'b1; dec_size = SZ_H; end
      OP_LW:         begin dec_mem = 1'b1; dec_size = SZ_W; end
      OP_SB:         begin dec_mem = 1'b1; dec_store = 1'b1; dec_size = SZ_B; end
      OP_SH:         begin dec_mem = 1'b1; dec_store = 1'b1; dec_size = SZ_H; end
      OP_SW:         begin dec_mem = 1'b1; dec_store = 1'b1; dec_size = SZ_W; end
      default:       ;
    endcase
    case (dec_size)
      SZ_H:    dec_misalign = mem_addr_i[0];
      SZ_W:    dec_misalign = |mem_addr_i[1:0];
      default: dec_misalign = 1'b0;
    endcase
  end

  // Store steering: replicate data across lanes and enable the addressed bytes.
  always_comb begin
    st_lane  = BIG_ENDIAN ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
    st_hsel  = BIG_ENDIAN ? ~mem_addr_i[1] : mem_addr_i[1];
    st_be    = 4'b1111;
    st_wdata = mem_sdata_i;
    case (dec_size)
      SZ_B: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{mem_sdata_i[7:0]}};
      end
      SZ_H: begin
        st_be    = st_hsel ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_sdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting from the latched opcode and low address bits.
  always_comb begin
    ld_lane = BIG_ENDIAN ? ~lo_q : lo_q;
    ld_hsel = BIG_ENDIAN ? ~lo_q[1] : lo_q[1];
    ld_byte = mem_rdata_i[{ld_lane, 3'b000} +: 8];
    ld_half = ld_hsel ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  assign timeout = (MAX_WAIT > 0) && (cnt_q == WAIT_LAST);

  // Next-state, writeback and bus-request logic; stall is combinational.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    mwdata_d    = mwdata_q;
    op_d        = op_q;
    lo_d        = lo_q;
    lwd_d       = lwd_q;
    lwreg_d     = lwreg_q;
    exc_align_d = 1'b0;
    exc_bus_d   = 1'b0;
    stall_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!valid_i || !dec_mem) begin
          wd_d    = wd_i;
          wreg_d  = valid_i & wreg_i;
          wdata_d = wdata_i;
        end else if (dec_misalign) begin
          wreg_d      = 1'b0;
          exc_align_d = 1'b1;
        end else begin
          stall_o  = 1'b1;
          req_d    = 1'b1;
          we_d     = dec_store;
          addr_d   = {mem_addr_i[ADDR_W-1:2], 2'b00};
          be_d     = st_be;
          mwdata_d = st_wdata;
          op_d     = mem_op_i;
          lo_d     = mem_addr_i[1:0];
          lwd_d    = wd_i;
          lwreg_d  = wreg_i;
          cnt_d    = '0;
          wreg_d   = 1'b0;
          state_d  = S_BUS;
        end
      end
      S_BUS: begin
        if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          if (!we_q) begin
            wd_d    = lwd_q;
            wreg_d  = lwreg_q;
            wdata_d = ld_data;
          end else begin
            wreg_d  = 1'b0;
          end
        end else if (timeout) begin
          req_d     = 1'b0;
          exc_bus_d = 1'b1;
          wreg_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      mwdata_q    <= '0;
      op_q        <= '0;
      lo_q        <= '0;
      lwd_q       <= '0;
      lwreg_q     <= 1'b0;
      exc_align_q <= 1'b0;
      exc_bus_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      mwdata_q    <= mwdata_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      lwd_q       <= lwd_d;
      lwreg_q     <= lwreg_d;
      exc_align_q <= exc_align_d;
      exc_bus_q   <= exc_bus_d;
    end
  end

  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = mwdata_q;
  assign exc_align_o = exc_align_q;
  assign exc_bus_o   = exc_bus_q;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls: one big-endian and one little-endian
// instance share the same stimulus; expected values are hand-computed.
module tb_mem_stage_ls;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_i, wreg_i, mem_ack_i;
  logic [4:0]  wd_i;
  logic [31:0] wdata_i, mem_addr_i, mem_sdata_i, mem_rdata_i;
  logic [3:0]  mem_op_i;

  logic        stall_b, wreg_b, req_b, we_b, exa_b, exb_b;
  logic [4:0]  wd_b;
  logic [31:0] wdata_b, addr_b, mwd_b;
  logic [3:0]  be_b;

  logic        stall_l, wreg_l, req_l, we_l, exa_l, exb_l;
  logic [4:0]  wd_l;
  logic [31:0] wdata_l, addr_l, mwd_l;
  logic [3:0]  be_l;

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  mem_stage_ls #(.REG_AW(5), .ADDR_W(32), .MAX_WAIT(16), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_sdata_i(mem_sdata_i), .stall_o(stall_b), .wd_o(wd_b), .wreg_o(wreg_b),
    .wdata_o(wdata_b), .mem_req_o(req_b), .mem_we_o(we_b), .mem_addr_o(addr_b),
    .mem_be_o(be_b), .mem_wdata_o(mwd_b), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .exc_align_o(exa_b), .exc_bus_o(exb_b)
  );

  mem_stage_ls #(.REG_AW(5), .ADDR_W(32), .MAX_WAIT(16), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_sdata_i(mem_sdata_i), .stall_o(stall_l), .wd_o(wd_l), .wreg_o(wreg_l),
    .wdata_o(wdata_l), .mem_req_o(req_l), .mem_we_o(we_l), .mem_addr_o(addr_l),
    .mem_be_o(be_l), .mem_wdata_o(mwd_l), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .exc_align_o(exa_l), .exc_bus_o(exb_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] ob, input logic [31:0] ol,
                      input logic [31:0] exp);
    chk({tag, "/be"}, ob, exp);
    chk({tag, "/le"}, ol, exp);
  endtask

  task automatic drive(input int unsigned v, input int unsigned op, input int unsigned addr,
                       input int unsigned sdata, input int unsigned wd, input int unsigned wr,
                       input int unsigned wdat);
    valid_i     = 1'(v);
    mem_op_i    = 4'(op);
    mem_addr_i  = addr;
    mem_sdata_i = sdata;
    wd_i        = 5'(wd);
    wreg_i      = 1'(wr);
    wdata_i     = wdat;
  endtask

  // Capture an access, then acknowledge it in the first bus cycle.
  task automatic access_fast(input int unsigned op, input int unsigned addr,
                             input int unsigned sdata, input int unsigned wd,
                             input int unsigned rdata);
    drive(1, op, addr, sdata, wd, 1, 32'h0BAD_0BAD);
    tick();
    mem_ack_i   = 1'b1;
    mem_rdata_i = rdata;
    tick();
    mem_ack_i   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk2("rst_req",   32'(req_b),   32'(req_l),   0);
    chk2("rst_wreg",  32'(wreg_b),  32'(wreg_l),  0);
    chk2("rst_wd",    32'(wd_b),    32'(wd_l),    0);
    chk2("rst_wdata", wdata_b,      wdata_l,      0);
    chk2("rst_stall", 32'(stall_b), 32'(stall_l), 0);
    chk2("rst_exa",   32'(exa_b),   32'(exa_l),   0);
    chk2("rst_exb",   32'(exb_b),   32'(exb_l),   0);
    rst = 1'b0;

    // ALU pass-through
    drive(1, 0, 0, 0, 5, 1, 32'h1234);
    #1 chk2("alu_stall", 32'(stall_b), 32'(stall_l), 0);
    tick();
    chk2("alu_wd",    32'(wd_b),   32'(wd_l),   5);
    chk2("alu_wreg",  32'(wreg_b), 32'(wreg_l), 1);
    chk2("alu_wdata", wdata_b,     wdata_l,     32'h1234);
    chk2("alu_req",   32'(req_b),  32'(req_l),  0);

    // Opcode 9 behaves as NONE
    drive(1, 9, 32'h1000, 0, 7, 1, 32'hCAFE);
    #1 chk2("op9_stall", 32'(stall_b), 32'(stall_l), 0);
    tick();
    chk2("op9_wdata", wdata_b,    wdata_l,    32'hCAFE);
    chk2("op9_wreg",  32'(wreg_b), 32'(wreg_l), 1);
    chk2("op9_req",   32'(req_b),  32'(req_l),  0);

    // valid low suppresses the write enable
    drive(0, 0, 0, 0, 7, 1, 32'hBEEF);
    tick();
    chk2("inv_wreg", 32'(wreg_b), 32'(wreg_l), 0);

    // LB @0x1003 with three wait states
    drive(1, 1, 32'h1003, 0, 3, 1, 32'hDEAD);
    #1 chk2("lb_stall_cap", 32'(stall_b), 32'(stall_l), 1);
    tick();
    chk2("lb_req",  32'(req_b),  32'(req_l),  1);
    chk2("lb_we",   32'(we_b),   32'(we_l),   0);
    chk2("lb_addr", addr_b,      addr_l,      32'h1000);
    chk2("lb_bubble", 32'(wreg_b), 32'(wreg_l), 0);
    for (int i = 0; i < 3; i++) begin
      chk2("lb_stall_wait", 32'(stall_b), 32'(stall_l), 1);
      tick();
    end
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h8000_00F0;
    #1 chk2("lb_stall_ack", 32'(stall_b), 32'(stall_l), 0);
    tick();
    mem_ack_i = 1'b0;
    chk("lb_data/be", wdata_b, 32'hFFFF_FFF0);
    chk("lb_data/le", wdata_l, 32'hFFFF_FF80);
    chk2("lb_wreg", 32'(wreg_b), 32'(wreg_l), 1);
    chk2("lb_wd",   32'(wd_b),   32'(wd_l),   3);
    chk2("lb_req_done", 32'(req_b), 32'(req_l), 0);

    // LBU / LH / LHU / LW single-cycle-ack loads
    access_fast(2, 32'h1003, 0, 4, 32'h8000_00F0);
    chk("lbu_data/be", wdata_b, 32'h0000_00F0);
    chk("lbu_data/le", wdata_l, 32'h0000_0080);
    chk2("lbu_wd", 32'(wd_b), 32'(wd_l), 4);
    access_fast(3, 32'h1002, 0, 6, 32'h8C4F_20F0);
    chk("lh_data/be", wdata_b, 32'h0000_20F0);
    chk("lh_data/le", wdata_l, 32'hFFFF_8C4F);
    access_fast(4, 32'h1000, 0, 6, 32'h8C4F_20F0);
    chk("lhu_data/be", wdata_b, 32'h0000_8C4F);
    chk("lhu_data/le", wdata_l, 32'h0000_20F0);
    access_fast(5, 32'h1004, 0, 8, 32'h8C4F_20F0);
    chk2("lw_data", wdata_b, wdata_l, 32'h8C4F_20F0);
    chk2("lw_wd",   32'(wd_b), 32'(wd_l), 8);

    // SH @0x2002 with one wait state
    drive(1, 7, 32'h2002, 32'hABCD_1234, 9, 1, 0);
    #1 chk2("sh_stall_cap", 32'(stall_b), 32'(stall_l), 1);
    tick();
    chk2("sh_req",   32'(req_b), 32'(req_l), 1);
    chk2("sh_we",    32'(we_b),  32'(we_l),  1);
    chk2("sh_addr",  addr_b,     addr_l,     32'h2000);
    chk2("sh_wdata", mwd_b,      mwd_l,      32'h1234_1234);
    chk("sh_be/be", 32'(be_b), 32'h3);
    chk("sh_be/le", 32'(be_l), 32'hC);
    chk2("sh_bubble", 32'(wreg_b), 32'(wreg_l), 0);
    tick();
    chk2("sh_req_hold",  32'(req_b), 32'(req_l), 1);
    chk2("sh_addr_hold", addr_b,     addr_l,     32'h2000);
    chk("sh_be_hold/le", 32'(be_l), 32'hC);
    chk2("sh_stall_wait", 32'(stall_b), 32'(stall_l), 1);
    mem_ack_i = 1'b1;
    #1 chk2("sh_stall_ack", 32'(stall_b), 32'(stall_l), 0);
    tick();
    mem_ack_i = 1'b0;
    chk2("sh_wreg", 32'(wreg_b), 32'(wreg_l), 0);
    chk2("sh_req_done", 32'(req_b), 32'(req_l), 0);

    // SB @0x2001 and SW @0x2004
    drive(1, 6, 32'h2001, 32'h0000_00A5, 9, 1, 0);
    tick();
    chk("sb_be/be", 32'(be_b), 32'h4);
    chk("sb_be/le", 32'(be_l), 32'h2);
    chk2("sb_wdata", mwd_b, mwd_l, 32'hA5A5_A5A5);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk2("sb_wreg", 32'(wreg_b), 32'(wreg_l), 0);
    drive(1, 8, 32'h2004, 32'hABCD_1234, 9, 1, 0);
    tick();
    chk2("sw_be",    32'(be_b), 32'(be_l), 32'hF);
    chk2("sw_wdata", mwd_b,     mwd_l,     32'hABCD_1234);
    chk2("sw_addr",  addr_b,    addr_l,    32'h2004);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;

    // Misaligned LW and SH raise alignment exceptions without bus traffic
    drive(1, 5, 32'h3001, 0, 10, 1, 32'h55);
    #1 chk2("mis_stall", 32'(stall_b), 32'(stall_l), 0);
    tick();
    chk2("mis_exa",  32'(exa_b),  32'(exa_l),  1);
    chk2("mis_req",  32'(req_b),  32'(req_l),  0);
    chk2("mis_wreg", 32'(wreg_b), 32'(wreg_l), 0);
    drive(1, 7, 32'h3003, 0, 10, 1, 0);
    tick();
    chk2("mis_sh_exa", 32'(exa_b), 32'(exa_l), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk2("mis_exa_pulse", 32'(exa_b), 32'(exa_l), 0);
    chk2("mis_req_after", 32'(req_b), 32'(req_l), 0);

    // LW timeout: 16 request cycles, then a bus-error pulse
    drive(1, 5, 32'h4000, 0, 11, 1, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk2("to_req",   32'(req_b),   32'(req_l),   1);
      chk2("to_stall", 32'(stall_b), 32'(stall_l), (i < 15) ? 1 : 0);
      chk2("to_exb",   32'(exb_b),   32'(exb_l),   0);
      tick();
    end
    chk2("to_exb_pulse", 32'(exb_b), 32'(exb_l), 1);
    chk2("to_req_drop",  32'(req_b), 32'(req_l), 0);
    chk2("to_wreg",      32'(wreg_b), 32'(wreg_l), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk2("to_stall_rel", 32'(stall_b), 32'(stall_l), 0);
    tick();
    chk2("to_exb_clear", 32'(exb_b), 32'(exb_l), 0);

    // Ack on the last allowed cycle beats the timeout
    drive(1, 5, 32'h6000, 0, 12, 1, 0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk2("aw_req", 32'(req_b), 32'(req_l), 1);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h1357_9BDF;
    #1 chk2("aw_stall", 32'(stall_b), 32'(stall_l), 0);
    tick();
    mem_ack_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk2("aw_exb",   32'(exb_b),  32'(exb_l),  0);
    chk2("aw_wreg",  32'(wreg_b), 32'(wreg_l), 1);
    chk2("aw_wdata", wdata_b,     wdata_l,     32'h1357_9BDF);
    chk2("aw_wd",    32'(wd_b),   32'(wd_l),   12);

    // Reset while an access is outstanding
    drive(1, 5, 32'h5000, 0, 13, 1, 32'h77);
    tick();
    tick();
    chk2("rb_req_pre", 32'(req_b), 32'(req_l), 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk2("rb_req",   32'(req_b),   32'(req_l),   0);
    chk2("rb_stall", 32'(stall_b), 32'(stall_l), 0);
    chk2("rb_wreg",  32'(wreg_b),  32'(wreg_l),  0);
    chk2("rb_wdata", wdata_b,      wdata_l,      0);
    chk2("rb_addr",  addr_b,       addr_l,       0);
    chk2("rb_be",    32'(be_b),    32'(be_l),    0);
    rst = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFF_0000;
    tick();
    mem_ack_i = 1'b0;
    chk2("late_ack_wreg",  32'(wreg_b), 32'(wreg_l), 0);
    chk2("late_ack_wdata", wdata_b,     wdata_l,     0);
    chk2("late_ack_req",   32'(req_b),  32'(req_l),  0);

    // Normal operation resumes
    drive(1, 0, 0, 0, 31, 1, 32'hFFFF_FFFF);
    tick();
    chk2("post_wd",    32'(wd_b),   32'(wd_l),   31);
    chk2("post_wreg",  32'(wreg_b), 32'(wreg_l), 1);
    chk2("post_wdata", wdata_b,     wdata_l,     32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
